// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: the instruction/selector input channel,
// the immediate output channel and the synchronous flush.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator behind a 2-entry elastic buffer; the
// immediate is formed at push time and stored with its tag and illegal flag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic          clk,
    input logic          rst_n,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_I    = 3'b001;
    localparam logic [2:0] SEL_S    = 3'b010;
    localparam logic [2:0] SEL_B    = 3'b011;
    localparam logic [2:0] SEL_U    = 3'b100;
    localparam logic [2:0] SEL_J    = 3'b101;
    localparam logic [2:0] SEL_Z    = 3'b110;
    localparam logic [2:0] SEL_BAD  = 3'b111;

    // Every format is assembled as a 32-bit signed value whose bit 31 carries
    // the intended sign (0 for zimm), so a single sign extension fills XLEN.
    function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:0] ins,
                                                        input logic [2:0]  sel);
        logic signed [31:0] raw;
        raw = '0;
        case (sel)
            SEL_I:   raw = {{20{ins[31]}}, ins[31:20]};
            SEL_S:   raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            SEL_B:   raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            SEL_U:   raw = {ins[31:12], 12'b0};
            SEL_J:   raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            SEL_Z:   raw = {27'b0, ins[19:15]};
            SEL_NONE,
            SEL_BAD: raw = '0;
            default: raw = '0;
        endcase
        return XLEN'(raw);
    endfunction

    function automatic logic is_illegal(input logic [2:0] sel);
        return (sel == SEL_BAD);
    endfunction

    logic [1:0]              count;
    logic                    push;
    logic                    pop;

    logic signed [XLEN-1:0]  imm_p0;
    logic [TAG_W-1:0]        tag_p0;
    logic                    ill_p0;

    logic signed [XLEN-1:0]  head_imm_p1;
    logic [TAG_W-1:0]        head_tag_p1;
    logic                    head_ill_p1;
    logic signed [XLEN-1:0]  tail_imm_p1;
    logic [TAG_W-1:0]        tail_tag_p1;
    logic                    tail_ill_p1;

    logic                    unused_opcode;

    assign unused_opcode = ^bus.in_instr[6:0];

    // Ready depends only on the registered count, so out_ready never reaches in_ready.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);

    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready;

    // Stage p0: immediate formation for the incoming beat
    always_comb begin
        imm_p0 = gen_imm(bus.in_instr, bus.in_sel);
        tag_p0 = bus.in_tag;
        ill_p0 = is_illegal(bus.in_sel);
    end

    // Stage p1: head register (reset, drives the outputs) and occupancy control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 2'd0;
            head_imm_p1 <= '0;
            head_tag_p1 <= '0;
            head_ill_p1 <= 1'b0;
        end else if (bus.flush) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head_imm_p1 <= imm_p0;
                        head_tag_p1 <= tag_p0;
                        head_ill_p1 <= ill_p0;
                        count       <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: begin
                            head_imm_p1 <= imm_p0;
                            head_tag_p1 <= tag_p0;
                            head_ill_p1 <= ill_p0;
                        end
                        2'b10:   count <= 2'd2;
                        2'b01:   count <= 2'd0;
                        default: count <= 2'd1;
                    endcase
                end
                2'd2: begin
                    if (pop) begin
                        head_imm_p1 <= tail_imm_p1;
                        head_tag_p1 <= tail_tag_p1;
                        head_ill_p1 <= tail_ill_p1;
                        count       <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    // Stage p1: tail register, only meaningful while count is 2
    always_ff @(posedge clk) begin
        if ((count == 2'd1) && push && !pop) begin
            tail_imm_p1 <= imm_p0;
            tail_tag_p1 <= tag_p0;
            tail_ill_p1 <= ill_p0;
        end
    end

    assign bus.out_imm     = head_imm_p1;
    assign bus.out_tag     = head_tag_p1;
    assign bus.out_illegal = head_ill_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked every cycle against a queue-based FIFO model.
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_instr = '0;
    logic [2:0]       in_sel = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_ready = 1'b0;

    int total = 0;
    int bad = 0;
    ent_t q[$];

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

    assign if32.flush = flush;     assign if64.flush = flush;
    assign if32.in_valid = in_valid; assign if64.in_valid = in_valid;
    assign if32.in_instr = in_instr; assign if64.in_instr = in_instr;
    assign if32.in_sel = in_sel;   assign if64.in_sel = in_sel;
    assign if32.in_tag = in_tag;   assign if64.in_tag = in_tag;
    assign if32.out_ready = out_ready; assign if64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Immediate value as a plain integer, truncated by the caller for XLEN=32.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] sel);
        longint v;
        v = 0;
        case (sel)
            3'd1: v = $signed(i[31:20]);
            3'd2: v = $signed({i[31:25], i[11:7]});
            3'd3: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            3'd4: begin v = $signed(i[31:12]); v = v * 4096; end
            3'd5: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            3'd6: v = longint'(i[19:15]);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic void model_step();
        int   n;
        ent_t e;
        n = q.size();
        if (flush) begin
            q.delete();
            return;
        end
        if (n != 0 && out_ready) void'(q.pop_front());
        if (n < 2 && in_valid) begin
            e.imm = ref_imm(in_instr, in_sel);
            e.tag = in_tag;
            e.ill = (in_sel == 3'd7);
            q.push_back(e);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else model_step();
    end

    always @(negedge clk) begin
        chk("in_ready32", if32.in_ready, q.size() < 2);
        chk("in_ready64", if64.in_ready, q.size() < 2);
        chk("out_valid32", if32.out_valid, q.size() != 0);
        chk("out_valid64", if64.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("imm32", if32.out_imm, {32'b0, q[0].imm[31:0]});
            chk("imm64", if64.out_imm, q[0].imm);
            chk("tag32", if32.out_tag, q[0].tag);
            chk("tag64", if64.out_tag, q[0].tag);
            chk("ill32", if32.out_illegal, q[0].ill);
            chk("ill64", if64.out_illegal, q[0].ill);
        end
        if (!rst_n) begin
            chk("rst_imm64", if64.out_imm, 64'h0);
            chk("rst_tag64", if64.out_tag, 64'h0);
            chk("rst_ill64", if64.out_illegal, 64'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s,
                         input logic [TAG_W-1:0] t);
        in_valid = v;
        in_instr = ins;
        in_sel   = s;
        in_tag   = t;
    endtask

    logic [31:0] t2_ins [4] = '{32'hFE000EE3, 32'h0080006F, 32'h000FD073, 32'h00000013};
    logic [2:0]  t2_sel [4] = '{3'd3, 3'd5, 3'd6, 3'd7};
    logic [31:0] t2_exp [4] = '{32'hFFFFFFFC, 32'h00000008, 32'h0000001F, 32'h00000000};
    logic        t2_ill [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // reset state
        #2;
        chk("reset_out_valid", if32.out_valid, 64'd0);
        chk("reset_in_ready", if32.in_ready, 64'd1);
        chk("reset_imm32", if32.out_imm, 64'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // single I-type beat
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'd1, 5'd1);
        cyc();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        @(negedge clk);
        chk("t1_valid", if32.out_valid, 64'd1);
        chk("t1_imm", if32.out_imm, 64'hFFFFFFFF);
        chk("t1_tag", if32.out_tag, 64'd1);
        chk("t1_ill", if32.out_illegal, 64'd0);
        cyc();

        // back-to-back B, J, Z, illegal
        drive(1'b1, t2_ins[0], t2_sel[0], 5'd20);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i < 3) drive(1'b1, t2_ins[i+1], t2_sel[i+1], 5'(21 + i));
            else drive(1'b0, 32'h0, 3'd0, 5'd0);
            @(negedge clk);
            chk("t2_valid", if32.out_valid, 64'd1);
            chk("t2_imm", if32.out_imm, {32'b0, t2_exp[i]});
            chk("t2_tag", if32.out_tag, 64'(20 + i));
            chk("t2_ill", if32.out_illegal, {63'b0, t2_ill[i]});
        end
        cyc();

        // backpressure: third beat held off
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'd1, 5'd10);
        cyc();
        drive(1'b1, 32'h00200093, 3'd1, 5'd11);
        cyc();
        drive(1'b1, 32'h00300093, 3'd1, 5'd12);
        @(negedge clk);
        chk("t3_full", if32.in_ready, 64'd0);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_still_full", if32.in_ready, 64'd0);
        chk("t3_head_a", if32.out_imm, 64'd1);
        cyc();
        @(negedge clk);
        chk("t3_head_b", if32.out_imm, 64'd2);
        chk("t3_ready", if32.in_ready, 64'd1);
        cyc();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        @(negedge clk);
        chk("t3_head_c", if32.out_imm, 64'd3);
        chk("t3_tag_c", if32.out_tag, 64'd12);
        cyc();
        @(negedge clk);
        chk("t3_empty", if32.out_valid, 64'd0);

        // XLEN=64 sign extension
        cyc();
        drive(1'b1, 32'h800002B7, 3'd4, 5'd3);
        cyc();
        drive(1'b1, 32'h00112223, 3'd2, 5'd4);
        @(negedge clk);
        chk("t4_u64", if64.out_imm, 64'hFFFFFFFF80000000);
        chk("t4_u32", if32.out_imm, 64'h80000000);
        cyc();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        @(negedge clk);
        chk("t4_s64", if64.out_imm, 64'h0000000000000004);
        cyc();

        // flush at count 2 and at count 1 with a concurrent push
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 3'd1, 5'd5);
        cyc();
        drive(1'b1, 32'h00600093, 3'd1, 5'd6);
        cyc();
        flush = 1'b1;
        drive(1'b1, 32'h00700093, 3'd1, 5'd7);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_valid", if32.out_valid, 64'd0);
        chk("t5_ready", if32.in_ready, 64'd1);
        cyc();
        @(negedge clk);
        chk("t5_no_ghost", if32.out_valid, 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 32'h00800093, 3'd1, 5'd8);
        cyc();
        flush = 1'b1;
        drive(1'b1, 32'h00900093, 3'd1, 5'd9);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        @(negedge clk);
        chk("t5_flush1", if32.out_valid, 64'd0);
        cyc();

        // asynchronous reset mid-stream
        drive(1'b1, 32'h00A00093, 3'd1, 5'd13);
        cyc();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        #2;
        chk("t6_pre", if32.out_valid, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", if32.out_valid, 64'd0);
        chk("t6_async_imm", if32.out_imm, 64'd0);
        chk("t6_async_ready", if32.in_ready, 64'd1);
        drive(1'b1, 32'h00B00093, 3'd1, 5'd14);
        cyc();
        cyc();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        drive(1'b1, 32'h00C00093, 3'd1, 5'd15);
        cyc();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        @(negedge clk);
        chk("t6_new_imm", if32.out_imm, 64'd12);
        chk("t6_new_tag", if32.out_tag, 64'd15);
        cyc();
        @(negedge clk);
        chk("t6_alone", if32.out_valid, 64'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc();
            drive($urandom_range(0, 1) == 1, $urandom, 3'($urandom_range(0, 7)),
                  TAG_W'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 31) == 0);
        end
        cyc();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
